// File: rtl/ahb_gpio_master.sv
// ahb_gpio_master: turns single register commands into AHB-Lite word transfers
// aimed at a GPIO block. At most one transfer is in flight. A wait counter
// flags (without aborting) a slave that holds HREADY low too long.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is high only while the block is idle, and
// each accepted command produces exactly one single-cycle rsp_valid pulse
// (no back-pressure on the response side).
module ahb_gpio_master #(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        stall_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // Wide enough to hold TIMEOUT itself (saturation value).
  localparam int           CW   = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t        state;
  logic          wr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] wait_cnt;

  // Only word transfers are ever issued.
  assign HSIZE     = 3'b010;
  assign cmd_ready = (state == IDLE);
  assign state_dbg = state;

  // Transfer sequencer: all bus and response outputs are registered here.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      stall_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q      <= cmd_write;
            wdata_q   <= cmd_wdata;
            // Byte-lane bits of the offset are dropped: word access only.
            HADDR     <= BASE_ADDR | {24'h0, cmd_addr[7:2], 2'b00};
            HWRITE    <= cmd_write;
            HTRANS    <= TR_NONSEQ;
            stall_err <= 1'b0;
            wait_cnt  <= '0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (HREADY) begin
            HTRANS   <= TR_IDLE;
            HWDATA   <= wr_q ? wdata_q : 32'h0;
            wait_cnt <= '0;
            state    <= DATA;
          end else if (wait_cnt != TMAX) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt + CW'(1) == TMAX) stall_err <= 1'b1;
          end
        end
        DATA: begin
          if (HREADY) begin
            rsp_rdata <= wr_q ? 32'h0 : HRDATA;
            rsp_valid <= 1'b1;
            HWDATA    <= '0;
            wait_cnt  <= '0;
            state     <= RESP;
          end else if (wait_cnt != TMAX) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt + CW'(1) == TMAX) stall_err <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ahb_gpio_master.md
AHB_GPIO_MASTER -- requirements
Module: ahb_gpio_master

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h5000_0000, GPIO peripheral base address.
REQ-002 Parameter: TIMEOUT, default 255, maximum consecutive wait-state cycles before stall_err sets.
REQ-003 HCLK  input  1  single clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  8  register byte offset (0x00 data, 0x04 direction).
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  read data; 0 for writes.
REQ-012 stall_err  output  1  sticky wait-state timeout flag.
REQ-013 HADDR  output  32  AHB-Lite address.
REQ-014 HTRANS  output  2  AHB-Lite transfer type; only IDLE (2'b00) and NONSEQ (2'b10) used.
REQ-015 HWRITE  output  1  AHB-Lite direction.
REQ-016 HSIZE  output  3  constant 3'b010 (word).
REQ-017 HWDATA  output  32  AHB-Lite write data.
REQ-018 HREADY  input  1  AHB-Lite ready from slave or interconnect.
REQ-019 HRDATA  input  32  AHB-Lite read data.

Function
REQ-020 The block SHALL implement states IDLE, ADDR, DATA, RESP, with one transfer outstanding at most.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready, latching cmd_write, cmd_addr and cmd_wdata.
REQ-022 Acceptance SHALL move IDLE->ADDR and clear stall_err.
REQ-023 In ADDR the block SHALL drive HTRANS=2'b10, HADDR=BASE_ADDR | {cmd_addr[7:2],2'b00}, and HWRITE=cmd_write; cmd_addr[1:0] are ignored.
REQ-024 The block SHALL stay in ADDR while HREADY=0, holding all address-phase outputs; on an edge with HREADY=1 it SHALL move to DATA.
REQ-025 In DATA the block SHALL drive HTRANS=2'b00 and hold HADDR/HWRITE at their last values; for writes HWDATA SHALL equal the latched wdata, otherwise HWDATA=0.
REQ-026 The block SHALL stay in DATA while HREADY=0, holding HWDATA.
REQ-027 On an edge in DATA with HREADY=1, the block SHALL capture HRDATA into rsp_rdata for reads (0 for writes) and move to RESP.
REQ-028 In RESP, rsp_valid SHALL be 1 for exactly one cycle, rsp_rdata SHALL be stable, and the next state SHALL be IDLE; rsp_valid SHALL be 0 in all other states.
REQ-029 Zero-wait latency SHALL be: accept at edge N, address phase in cycle N+1, data phase in cycle N+2, rsp_valid in cycle N+3; each wait cycle adds one cycle.
REQ-030 A command presented during ADDR, DATA or RESP SHALL NOT be accepted; back-to-back commands SHALL start no earlier than the IDLE cycle after RESP.
REQ-031 A wait counter SHALL count consecutive HREADY=0 cycles in ADDR or DATA, SHALL reset on state change, and SHALL saturate at TIMEOUT.
REQ-032 stall_err SHALL set on the edge where the counter reaches TIMEOUT; the transfer SHALL NOT be aborted, and the block SHALL keep waiting for HREADY=1.
REQ-033 In IDLE, HTRANS SHALL be 2'b00 and HWDATA SHALL be 0.

Reset
REQ-034 HRESETn=0 SHALL asynchronously force state IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, stall_err=0, and wait counter=0.
REQ-035 Reset asserted mid-transfer SHALL discard the transfer with no rsp_valid; cmd_ready SHALL be 1 on the first edge after HRESETn deasserts.

Verification
REQ-036 Write, offset 0x04, wdata 0x0000_FFFF, HREADY=1 -> one cycle with HADDR=0x5000_0004, HTRANS=2'b10, HWRITE=1; next cycle HWDATA=0x0000_FFFF; then rsp_valid=1 with rsp_rdata=0.
REQ-037 Read, offset 0x00, HRDATA=0x0001_A5A5 in the data phase -> HWRITE=0, HWDATA=0, rsp_valid=1 with rsp_rdata=0x0001_A5A5 three cycles after acceptance.
REQ-038 Write with HREADY=0 for 3 data-phase cycles -> HWDATA held 4 cycles, rsp_valid delayed 3 cycles, stall_err=0.
REQ-039 TIMEOUT=4, HREADY=0 for 6 cycles in ADDR -> stall_err=1 after the 4th cycle, address held, transfer then completes; the next accepted command clears stall_err.
REQ-040 HRESETn pulsed low during DATA -> all outputs take reset values immediately, no rsp_valid, cmd_ready=1 after release.
REQ-041 cmd_valid held high for two commands -> cmd_ready=0 from acceptance through RESP; second address phase begins two cycles after the first rsp_valid.
